// File: rtl/data_bus_controller.sv
// MEM-stage data bus sequencer: runs one CPU access against the RAM1 SRAM or the
// UART sharing the RAM1 data bus, stalling with busy and finishing with a one-cycle ack.
module data_bus_controller #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned SRAM_WAIT      = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ack,
  output logic        ram1_oe,
  output logic        ram1_we,
  output logic        ram1_en,
  output logic [17:0] ram1_addr,
  inout  wire  [15:0] ram1_data,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn
);

  localparam int unsigned CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SRAM_WAIT - 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_SR_RD       = 4'd1;
  localparam logic [3:0] S_SR_WR_SETUP = 4'd2;
  localparam logic [3:0] S_SR_WR       = 4'd3;
  localparam logic [3:0] S_SR_WR_HOLD  = 4'd4;
  localparam logic [3:0] S_U_RD_WAIT   = 4'd5;
  localparam logic [3:0] S_U_RD        = 4'd6;
  localparam logic [3:0] S_U_WR        = 4'd7;
  localparam logic [3:0] S_U_WR_TBRE   = 4'd8;
  localparam logic [3:0] S_U_WR_TSRE   = 4'd9;
  localparam logic [3:0] S_STAT        = 4'd10;
  localparam logic [3:0] S_DONE        = 4'd11;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             oe_q, oe_d;
  logic             we_q, we_d;
  logic             en_q, en_d;
  logic             rdn_q, rdn_d;
  logic             wrn_q, wrn_d;
  logic             drive_q, drive_d;

  // Next state, then every output derived from the next state so it lands in a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          addr_d  = address;
          wdata_d = wdata;
          write_d = req_write;
          cnt_d   = CNT_RELOAD;
          if (address == UART_STAT_ADDR)      state_d = S_STAT;
          else if (address == UART_DATA_ADDR) state_d = req_write ? S_U_WR : S_U_RD_WAIT;
          else                                state_d = req_write ? S_SR_WR_SETUP : S_SR_RD;
        end
      end
      S_SR_RD: begin
        if (cnt_q == '0) begin
          rdata_d = ram1_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SR_WR_SETUP: state_d = S_SR_WR;
      S_SR_WR: begin
        if (cnt_q == '0) state_d = S_SR_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SR_WR_HOLD: state_d = S_DONE;
      S_U_RD_WAIT:  if (data_ready) state_d = S_U_RD;
      S_U_RD: begin
        rdata_d = {8'h00, ram1_data[7:0]};
        state_d = S_DONE;
      end
      S_U_WR:       state_d = S_U_WR_TBRE;
      S_U_WR_TBRE:  if (tbre) state_d = S_U_WR_TSRE;
      S_U_WR_TSRE:  if (tsre) state_d = S_DONE;
      S_STAT: begin
        // bit1 = receive byte pending, bit0 = transmitter fully idle; writes are dropped
        if (!write_q) rdata_d = {14'b0, data_ready, tbre & tsre};
        state_d = S_DONE;
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    ack_d   = (state_d == S_DONE);
    oe_d    = (state_d != S_SR_RD);
    we_d    = (state_d != S_SR_WR);
    en_d    = !(state_d inside {S_SR_RD, S_SR_WR_SETUP, S_SR_WR, S_SR_WR_HOLD});
    rdn_d   = (state_d != S_U_RD);
    wrn_d   = (state_d != S_U_WR);
    drive_d = (state_d inside {S_SR_WR_SETUP, S_SR_WR, S_SR_WR_HOLD, S_U_WR});
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      en_q    <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      en_q    <= en_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      drive_q <= drive_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign ram1_oe   = oe_q;
  assign ram1_we   = we_q;
  assign ram1_en   = en_q;
  assign rdn       = rdn_q;
  assign wrn       = wrn_q;
  assign ram1_addr = {2'b00, addr_q};
  assign ram1_data = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_data_bus_controller.sv
// Bench for data_bus_controller: directed cases plus random accesses, checked against
// a transaction-level model of latency, strobe counts and read data.
module tb_data_bus_controller;

  localparam int SW = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_read, req_write;
  logic [15:0] address, wdata;
  logic [15:0] rdata;
  logic        busy, ack;
  logic        ram1_oe, ram1_we, ram1_en;
  logic [17:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        data_ready, tbre, tsre;
  logic        rdn, wrn;

  // Environment: SRAM array and UART receive byte driving the shared bus
  logic [15:0] sram_mem [0:65535];
  logic [7:0]  uart_byte;
  logic        tb_en;
  logic [15:0] tb_val;

  assign tb_en     = (!ram1_oe && !ram1_en) || !rdn;
  assign tb_val    = !rdn ? {8'hC3, uart_byte} : sram_mem[ram1_addr[15:0]];
  assign ram1_data = tb_en ? tb_val : 16'hzzzz;

  always @(posedge CLK) if (!ram1_we && !ram1_en) sram_mem[ram1_addr[15:0]] <= ram1_data;

  always #5 CLK = ~CLK;

  data_bus_controller #(
    .UART_DATA_ADDR(16'hBF00),
    .UART_STAT_ADDR(16'hBF01),
    .SRAM_WAIT(SW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_read(req_read), .req_write(req_write),
    .address(address), .wdata(wdata),
    .rdata(rdata), .busy(busy), .ack(ack),
    .ram1_oe(ram1_oe), .ram1_we(ram1_we), .ram1_en(ram1_en),
    .ram1_addr(ram1_addr), .ram1_data(ram1_data),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .rdn(rdn), .wrn(wrn)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] wr_addrs [$];
  logic [15:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One access from IDLE; UART inputs rise at the given cycle index (0 = accept cycle).
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int dr_k, input int tbre_k,
                        input int tsre_k, input logic hold);
    int k, ack_k, exp_ack, busy_n, busy_at_ack;
    int oe_n, we_n, rdn_n, wrn_n, rdn_at, wrn_at, low_n;
    int e_oe, e_we, e_rdn, e_wrn, e_rdn_at, j0, m;
    logic is_stat, is_uart, is_sram, is_wr;
    is_wr   = wr;
    is_stat = (a == 16'hBF01);
    is_uart = (a == 16'hBF00);
    is_sram = !is_stat && !is_uart;
    e_oe = 0; e_we = 0; e_rdn = 0; e_wrn = 0; e_rdn_at = 0;

    if (is_stat) begin
      exp_ack = 2;
      if (!is_wr) exp_rdata = {14'b0, 1'(1 >= dr_k), 1'((1 >= tbre_k) && (1 >= tsre_k))};
    end else if (is_uart && !is_wr) begin
      j0 = (dr_k < 1) ? 1 : dr_k;
      e_rdn = 1; e_rdn_at = j0 + 1;
      exp_ack = j0 + 2;
      exp_rdata = {8'h00, uart_byte};
    end else if (is_uart) begin
      j0 = (tbre_k < 2) ? 2 : tbre_k;
      m  = (tsre_k < j0 + 1) ? j0 + 1 : tsre_k;
      e_wrn = 1;
      exp_ack = m + 1;
    end else if (is_wr) begin
      e_we = SW;
      exp_ack = SW + 3;
    end else begin
      e_oe = SW;
      exp_ack = SW + 1;
      exp_rdata = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    end

    check("idle_before", 32'(busy), 32'(0));
    req_read = rd; req_write = wr; address = a; wdata = d;
    data_ready = (0 >= dr_k); tbre = (0 >= tbre_k); tsre = (0 >= tsre_k);
    k = 0; ack_k = 0; busy_n = 0; busy_at_ack = 0;
    oe_n = 0; we_n = 0; rdn_n = 0; wrn_n = 0; rdn_at = 0; wrn_at = 0;
    while (ack_k == 0 && k < 80) begin
      step();
      k++;
      low_n = 0;
      if (!ram1_oe) begin low_n++; oe_n++; end
      if (!ram1_we) begin low_n++; we_n++; check("sram_wr_bus", 32'(ram1_data), 32'(d)); end
      if (!rdn)     begin low_n++; rdn_n++; rdn_at = k; end
      if (!wrn)     begin low_n++; wrn_n++; wrn_at = k; check("uart_wr_bus", 32'(ram1_data), 32'(d)); end
      check("strobe_excl", 32'(low_n <= 1), 32'(1));
      if (!is_sram) check("en_high_uart", 32'(ram1_en), 32'(1));
      if (is_sram && !ram1_en) check("sram_addr", 32'(ram1_addr), {14'b0, a});
      if (ack) begin
        ack_k = k;
        busy_at_ack = busy;
        req_read = 1'b0; req_write = 1'b0;
      end else begin
        busy_n += 32'(busy);
        if (hold) begin
          req_read = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
          address = 16'($urandom); wdata = 16'($urandom);
        end else begin
          req_read = 1'b0; req_write = 1'b0;
        end
      end
      data_ready = (k >= dr_k); tbre = (k >= tbre_k); tsre = (k >= tsre_k);
    end
    if (ack_k == 0) check("ack_timeout", 32'(0), 32'(1));

    check("ack_latency", ack_k, exp_ack);
    check("busy_cycles", busy_n, exp_ack - 1);
    check("busy_at_ack", 32'(busy_at_ack), 32'(0));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check("oe_cycles", oe_n, e_oe);
    check("we_cycles", we_n, e_we);
    check("rdn_cycles", rdn_n, e_rdn);
    check("wrn_cycles", wrn_n, e_wrn);
    if (e_rdn != 0) check("rdn_timing", rdn_at, e_rdn_at);
    if (e_wrn != 0) check("wrn_timing", wrn_at, 1);
    step();
    check("ack_one_cycle", 32'(ack), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    if (is_sram && is_wr) begin
      ref_mem[a] = d;
      wr_addrs.push_back(a);
    end
  endtask

  initial begin
    logic [15:0] a, d;
    logic rd, wr, hold;
    int kind;

    RST = 1'b0; req_read = 1'b0; req_write = 1'b0; address = '0; wdata = '0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; uart_byte = 8'h00;
    exp_rdata = 16'h0000;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_strobes", {27'b0, ram1_oe, ram1_we, ram1_en, rdn, wrn}, 32'h1F);
    RST = 1'b1;
    step();

    // SRAM write then read back
    access(1'b0, 1'b1, 16'h1234, 16'hABCD, 0, 0, 0, 1'b0);
    access(1'b1, 1'b0, 16'h1234, 16'h0000, 0, 0, 0, 1'b0);
    check("sram_rd_value", 32'(rdata), 32'hABCD);
    // Status read: read-ready set, transmitter not idle
    access(1'b1, 1'b0, 16'hBF01, 16'h0000, 0, 0, 100, 1'b0);
    check("stat_value", 32'(rdata), 32'h0002);
    // UART read after data_ready rises late
    uart_byte = 8'h5A;
    access(1'b1, 1'b0, 16'hBF00, 16'h0000, 6, 0, 0, 1'b0);
    check("uart_rd_value", 32'(rdata), 32'h005A);
    // UART write waiting on tbre then tsre
    access(1'b0, 1'b1, 16'hBF00, 16'h0041, 0, 3, 5, 1'b0);
    // Simultaneous read+write is a write; requests while busy are ignored
    access(1'b1, 1'b1, 16'h0010, 16'h7E57, 0, 0, 0, 1'b1);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 0, 1'b0);
    check("rw_prio_value", 32'(rdata), 32'h7E57);

    // Reset in the middle of an SRAM write
    req_write = 1'b1; address = 16'h7777; wdata = 16'h5555;
    step();
    req_write = 1'b0;
    step();
    check("mid_we_low", 32'(ram1_we), 32'(0));
    RST = 1'b0;
    step();
    check("abort_we", 32'(ram1_we), 32'(1));
    check("abort_en", 32'(ram1_en), 32'(1));
    check("abort_oe", 32'(ram1_oe), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ack", 32'(ack), 32'(0));
    check("abort_rdata", 32'(rdata), 32'(0));
    exp_rdata = 16'h0000;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_ack_after_abort", 32'(ack), 32'(0));
    end
    access(1'b1, 1'b0, 16'h1234, 16'h0000, 0, 0, 0, 1'b0);
    check("read_after_reset", 32'(rdata), 32'hABCD);

    // Random mix of all access kinds
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      d = 16'($urandom);
      hold = 1'($urandom_range(0, 1));
      uart_byte = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      wr = 1'b1;
      a = 16'($urandom_range(0, 63));
      case (kind)
        1: begin
          rd = 1'b1; wr = 1'b0;
          if (wr_addrs.size() > 0) a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        end
        2: begin a = 16'hBF00; rd = 1'b1; wr = 1'b0; end
        3: a = 16'hBF00;
        4: begin a = 16'hBF01; rd = 1'b1; wr = 1'b0; end
        5: a = 16'hBF01;
        default: ;
      endcase
      access(rd, wr, a, d, $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 6), hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
